// File: rtl/bullcow_display_if.sv
// rtl/bullcow_display_if.sv - game-core result bus and seven-segment outputs for bullcow_display
interface bullcow_display_if;
    logic       result_valid;
    logic [2:0] bulls;
    logic [2:0] cows;
    logic       game_over;
    logic       winner;
    logic [7:0] points_j1;
    logic [7:0] points_j2;
    logic [2:0] phase;
    logic [7:0] an;
    logic [7:0] dec_cat;

    modport master (
        output result_valid, bulls, cows, game_over, winner,
               points_j1, points_j2, phase,
        input  an, dec_cat
    );

    modport slave (
        input  result_valid, bulls, cows, game_over, winner,
               points_j1, points_j2, phase,
        output an, dec_cat
    );
endinterface

// File: rtl/bullcow_display.sv
// rtl/bullcow_display.sv - score/result/winner view on an 8-digit multiplexed seven-segment display
module bullcow_display #(
    parameter int REFRESH_DIV = 100000,
    parameter int HOLD_CYCLES = 200000000,
    parameter int BLINK_DIV   = 50000000
) (
    input  logic             clock,
    input  logic             reset,
    bullcow_display_if.slave bus
);

    localparam int RW = $clog2(REFRESH_DIV);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int BW = $clog2(2 * BLINK_DIV);

    // Glyph codes: 0..15 are hex digits, the rest are letters and blank.
    localparam logic [4:0] C_BLANK = 5'd16;
    localparam logic [4:0] C_P     = 5'd17;
    localparam logic [4:0] C_B     = 5'd18;
    localparam logic [4:0] C_C     = 5'd19;

    typedef enum logic [1:0] {
        MODE_SCORE,
        MODE_RESULT,
        MODE_WIN
    } mode_t;

    mode_t       mode;
    mode_t       mode_nxt;
    logic        go_q;
    logic        go_rise;
    logic        latch_res;
    logic        hold_done;
    logic        blank_all;
    logic [RW-1:0] refresh_cnt;
    logic [2:0]  idx;
    logic [HW-1:0] hold_cnt;
    logic [BW-1:0] blink_cnt;
    logic [2:0]  bulls_l;
    logic [2:0]  cows_l;
    logic        winner_l;
    logic [4:0]  code;

    function automatic logic [7:0] glyph(input logic [4:0] c);
        case (c)
            5'd0:    glyph = 8'hC0;
            5'd1:    glyph = 8'hF9;
            5'd2:    glyph = 8'hA4;
            5'd3:    glyph = 8'hB0;
            5'd4:    glyph = 8'h99;
            5'd5:    glyph = 8'h92;
            5'd6:    glyph = 8'h82;
            5'd7:    glyph = 8'hF8;
            5'd8:    glyph = 8'h80;
            5'd9:    glyph = 8'h90;
            5'd10:   glyph = 8'h88;
            5'd11:   glyph = 8'h83;
            5'd12:   glyph = 8'hC6;
            5'd13:   glyph = 8'hA1;
            5'd14:   glyph = 8'h86;
            5'd15:   glyph = 8'h8E;
            C_P:     glyph = 8'h8C;
            C_B:     glyph = 8'h83;
            C_C:     glyph = 8'hA7;
            default: glyph = 8'hFF;
        endcase
    endfunction

    // A game_over level that is already high when reset releases counts as a rise.
    assign go_rise   = bus.game_over & ~go_q;
    // Ending the game outranks a simultaneous guess result, and WIN ignores results.
    assign latch_res = bus.result_valid & ~go_rise & (mode != MODE_WIN);
    assign hold_done = (hold_cnt == HW'(HOLD_CYCLES - 1));
    assign blank_all = (mode == MODE_WIN) && (blink_cnt >= BW'(BLINK_DIV));

    // Mode register and game_over edge history.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mode <= MODE_SCORE;
            go_q <= 1'b0;
        end else begin
            mode <= mode_nxt;
            go_q <= bus.game_over;
        end
    end

    // Next mode: game_over rise, then result_valid, then the hold timer.
    always_comb begin
        mode_nxt = mode;
        case (mode)
            MODE_SCORE: begin
                if (go_rise)
                    mode_nxt = MODE_WIN;
                else if (bus.result_valid)
                    mode_nxt = MODE_RESULT;
            end
            MODE_RESULT: begin
                if (go_rise)
                    mode_nxt = MODE_WIN;
                else if (bus.result_valid)
                    mode_nxt = MODE_RESULT;
                else if (hold_done)
                    mode_nxt = MODE_SCORE;
            end
            MODE_WIN: begin
                if (!bus.game_over)
                    mode_nxt = MODE_SCORE;
            end
            default: mode_nxt = MODE_SCORE;
        endcase
    end

    // Result latch and hold timer; a fresh result restarts the hold.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bulls_l  <= 3'd0;
            cows_l   <= 3'd0;
            hold_cnt <= '0;
        end else if (latch_res) begin
            bulls_l  <= bus.bulls;
            cows_l   <= bus.cows;
            hold_cnt <= '0;
        end else if (mode == MODE_RESULT) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    // Winner latch and blink phase counter, restarted on entry to WIN.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            winner_l  <= 1'b0;
            blink_cnt <= '0;
        end else if (go_rise) begin
            winner_l  <= bus.winner;
            blink_cnt <= '0;
        end else if (mode == MODE_WIN) begin
            if (blink_cnt == BW'(2 * BLINK_DIV - 1))
                blink_cnt <= '0;
            else
                blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Digit scan: advance the active digit once per refresh period.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            refresh_cnt <= '0;
            idx         <= 3'd0;
        end else if (refresh_cnt == RW'(REFRESH_DIV - 1)) begin
            refresh_cnt <= '0;
            idx         <= idx + 3'd1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    // Content of the active digit for the current view.
    always_comb begin
        code = C_BLANK;
        case (mode)
            MODE_SCORE: begin
                case (idx)
                    3'd7:    code = {1'b0, bus.points_j1[7:4]};
                    3'd6:    code = {1'b0, bus.points_j1[3:0]};
                    3'd4:    code = {2'b00, bus.phase};
                    3'd1:    code = {1'b0, bus.points_j2[7:4]};
                    3'd0:    code = {1'b0, bus.points_j2[3:0]};
                    default: code = C_BLANK;
                endcase
            end
            MODE_RESULT: begin
                case (idx)
                    3'd7:    code = C_B;
                    3'd6:    code = {2'b00, bulls_l};
                    3'd3:    code = C_C;
                    3'd2:    code = {2'b00, cows_l};
                    default: code = C_BLANK;
                endcase
            end
            MODE_WIN: begin
                case (idx)
                    3'd7:    code = C_P;
                    3'd6:    code = 5'd1 + {4'd0, winner_l};
                    default: code = C_BLANK;
                endcase
            end
            default: code = C_BLANK;
        endcase
    end

    // Registered drivers so the anode and segment lines change together.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.an      <= 8'hFF;
            bus.dec_cat <= 8'hFF;
        end else begin
            bus.an      <= blank_all ? 8'hFF : ~(8'h01 << idx);
            bus.dec_cat <= glyph(code);
        end
    end

endmodule

// File: tb/tb_bullcow_display.sv
// tb/tb_bullcow_display.sv - directed self-checking bench for bullcow_display
module tb_bullcow_display;

    localparam int RD = 4;
    localparam int HC = 20;
    localparam int BD = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   cyc;
    int   n_vec = 0;
    int   n_err = 0;
    int   n;
    logic [7:0] score_tab [8];

    bullcow_display_if bus ();

    bullcow_display #(
        .REFRESH_DIV (RD),
        .HOLD_CYCLES (HC),
        .BLINK_DIV   (BD)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Cycles since reset release; cycle n is the n-th posedge after release.
    always @(posedge clock or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] an_of(input int k);
        logic [7:0] one;
        one = 8'h01;
        return ~(one << k);
    endfunction

    task automatic step_to(input int t);
        while (cyc < t) @(negedge clock);
    endtask

    // First cycle (after n) whose registered outputs show digit slot pos.
    function automatic int next_slot(input int pos);
        int t;
        t = cyc + 1;
        while (!(((t - 1) % RD == 0) && (((t - 1) / RD) % 8 == pos))) t++;
        return t;
    endfunction

    task automatic chk_both(input int t, input string tag, input logic [7:0] an_e, input logic [7:0] dec_e);
        step_to(t);
        check({tag, ".an"}, bus.an, an_e);
        check({tag, ".dec"}, bus.dec_cat, dec_e);
    endtask

    task automatic chk_an(input int t, input string tag, input logic [7:0] an_e);
        step_to(t);
        check({tag, ".an"}, bus.an, an_e);
    endtask

    initial begin
        bus.result_valid = 1'b0;
        bus.bulls        = 3'd0;
        bus.cows         = 3'd0;
        bus.game_over    = 1'b0;
        bus.winner       = 1'b0;
        bus.points_j1    = 8'h03;
        bus.points_j2    = 8'h12;
        bus.phase        = 3'd2;
        score_tab[0] = 8'hA4; score_tab[1] = 8'hF9; score_tab[2] = 8'hFF; score_tab[3] = 8'hFF;
        score_tab[4] = 8'hA4; score_tab[5] = 8'hFF; score_tab[6] = 8'hB0; score_tab[7] = 8'hC0;

        // Reset values, then score view scan across a full wrap.
        repeat (2) @(negedge clock);
        check("rst.an", bus.an, 8'hFF);
        check("rst.dec", bus.dec_cat, 8'hFF);
        reset = 1'b1;
        for (int k = 0; k <= 8; k++)
            chk_both(1 + RD * k, $sformatf("scan%0d", k), an_of(k % 8), score_tab[k % 8]);

        // Single result: b2 c1, view held exactly HC cycles.
        n = next_slot(6);
        step_to(n);
        bus.bulls = 3'd2; bus.cows = 3'd1; bus.result_valid = 1'b1;
        step_to(n + 1);
        bus.result_valid = 1'b0;
        check("resA.pre", bus.dec_cat, 8'hB0);
        chk_both(n + 2,  "resA.b2",   8'hBF, 8'hA4);
        chk_both(n + 4,  "resA.b",    8'h7F, 8'h83);
        chk_both(n + 16, "resA.c1",   8'hFB, 8'hF9);
        chk_both(n + 21, "resA.last", 8'hF7, 8'hA7);
        chk_both(n + 22, "resA.back", 8'hF7, 8'hFF);

        // Second result 10 cycles in restarts the hold.
        n = next_slot(2);
        step_to(n);
        bus.bulls = 3'd2; bus.cows = 3'd1; bus.result_valid = 1'b1;
        step_to(n + 1);
        bus.result_valid = 1'b0;
        chk_both(n + 2, "resB.c1", 8'hFB, 8'hF9);
        chk_both(n + 4, "resB.c",  8'hF7, 8'hA7);
        step_to(n + 10);
        bus.bulls = 3'd0; bus.cows = 3'd3; bus.result_valid = 1'b1;
        step_to(n + 11);
        bus.result_valid = 1'b0;
        chk_both(n + 16, "resB.b0",   8'hBF, 8'hC0);
        chk_both(n + 20, "resB.b",    8'h7F, 8'h83);
        chk_both(n + 22, "resB.held", 8'h7F, 8'h83);
        chk_both(n + 32, "resB.back", 8'hFB, 8'hFF);

        // Winner view entered together with a result pulse; blink and exit.
        n = next_slot(6);
        step_to(n);
        bus.game_over = 1'b1; bus.winner = 1'b1; bus.result_valid = 1'b1;
        bus.bulls = 3'd5; bus.cows = 3'd6;
        step_to(n + 1);
        bus.result_valid = 1'b0;
        chk_both(n + 2,  "win.num",  8'hBF, 8'hA4);
        chk_both(n + 4,  "win.P",    8'h7F, 8'h8C);
        chk_both(n + 9,  "win.on7",  8'hFE, 8'hFF);
        chk_an  (n + 10, "win.off8", 8'hFF);
        chk_an  (n + 17, "win.off15", 8'hFF);
        chk_an  (n + 18, "win.on0",  8'hFB);
        chk_an  (n + 26, "win.off2", 8'hFF);
        step_to(n + 32);
        bus.game_over = 1'b0;
        chk_an  (n + 33, "win.exit0", 8'hFF);
        chk_both(n + 34, "win.exit1", 8'hBF, 8'hB0);

        // Out-of-range counts shown as raw hex digits.
        n = next_slot(6);
        step_to(n);
        bus.bulls = 3'd7; bus.cows = 3'd5; bus.result_valid = 1'b1;
        step_to(n + 1);
        bus.result_valid = 1'b0;
        chk_both(n + 2,  "hex.b7", 8'hBF, 8'hF8);
        chk_both(n + 16, "hex.c5", 8'hFB, 8'h92);

        // Asynchronous reset in the middle of a result view.
        n = next_slot(6);
        step_to(n);
        bus.bulls = 3'd2; bus.cows = 3'd1; bus.result_valid = 1'b1;
        step_to(n + 1);
        bus.result_valid = 1'b0;
        step_to(n + 5);
        #2;
        reset = 1'b0;
        #1;
        check("arst.an", bus.an, 8'hFF);
        check("arst.dec", bus.dec_cat, 8'hFF);
        @(negedge clock);
        reset = 1'b1;
        chk_both(1, "arst.rel1", 8'hFE, 8'hA4);
        chk_both(5, "arst.rel5", 8'hFD, 8'hF9);

        // Live score sampling.
        bus.points_j1 = 8'h09;
        n = next_slot(6);
        chk_both(n, "live.9", 8'hBF, 8'h90);
        step_to(n + 5);
        bus.points_j1 = 8'h0A;
        chk_both(n + 32, "live.A", 8'hBF, 8'h88);

        // game_over already high when reset releases.
        @(negedge clock);
        reset = 1'b0;
        bus.game_over = 1'b1;
        bus.winner = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        chk_both(1,  "gorst.score", 8'hFE, 8'hA4);
        chk_both(2,  "gorst.win",   8'hFE, 8'hFF);
        chk_both(25, "gorst.num",   8'hBF, 8'hF9);
        chk_an  (26, "gorst.blink", 8'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
